// File: rtl/hazard_ctrl.sv
// Hazard control for a five-stage pipeline: operand forwarding selects, load-use
// and multi-cycle-op stalls, branch flushes, and a single-entry scoreboard that
// tracks one fixed-latency multiply/divide op in flight.
// Optional feature: define HAZARD_PERF_EN to add saturating 32-bit stall/flush
// counters (StallCnt, FlushCnt).
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MulReqD,
  input  logic              MulStartE,
  input  logic [REG_AW-1:0] MulRdE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MulBusy,
  output logic              MulDoneW
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);

  // Counter loads MDU_LAT-1 so the done cycle lands exactly MDU_LAT cycles after issue.
  localparam int unsigned    CntW    = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MDU_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;

  logic busy;
  logic done;
  logic lw_stall;
  logic mul_stall;
  logic struct_stall;
  logic stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign busy = (state_q == StBusy);
  assign done = busy && (cnt_q == '0);

  // Scoreboard register: state, remaining-latency counter, pending destination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

  // Scoreboard next state; a start while busy is only honoured on the done cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      StIdle: begin
        if (MulStartE) begin
          state_d   = StBusy;
          cnt_d     = CntLoad;
          pend_rd_d = MulRdE;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (MulStartE) begin
          state_d   = StBusy;
          cnt_d     = CntLoad;
          pend_rd_d = MulRdE;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Forwarding selects: Memory stage wins over Writeback; x0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E)) begin
      fwd_a = 2'b10;
    end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E)) begin
      fwd_a = 2'b01;
    end
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E)) begin
      fwd_b = 2'b10;
    end else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E)) begin
      fwd_b = 2'b01;
    end
  end

  // Stall sources; the multi-cycle result is forwardable on its done cycle.
  always_comb begin
    lw_stall     = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
    mul_stall    = busy && !done && (pend_rd_q != '0) &&
                   ((pend_rd_q == Rs1_D) || (pend_rd_q == Rs2_D));
    struct_stall = MulReqD && busy && !done;
    stall        = lw_stall || mul_stall || struct_stall;
  end

  // Pipeline controls, forced quiet while reset is held; a taken branch beats any stall.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = stall && !PCSrcE;
      StallD    = stall && !PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = stall || PCSrcE;
    end
  end

  assign MulBusy  = busy;
  assign MulDoneW = done;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_LAT=4, REG_AW=5).
// Also exercises the counters when built with HAZARD_PERF_EN.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W, MulRdE;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulReqD, MulStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE, MulBusy, MulDoneW;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .MDU_LAT(4),
    .REG_AW (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1_D     (Rs1_D),
    .Rs2_D     (Rs2_D),
    .Rs1_E     (Rs1_E),
    .Rs2_E     (Rs2_E),
    .RD_E      (RD_E),
    .RD_M      (RD_M),
    .RD_W      (RD_W),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ResultSrcE(ResultSrcE),
    .PCSrcE    (PCSrcE),
    .MulReqD   (MulReqD),
    .MulStartE (MulStartE),
    .MulRdE    (MulRdE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .MulBusy   (MulBusy),
    .MulDoneW  (MulDoneW)
`ifdef HAZARD_PERF_EN
    ,
    .StallCnt  (StallCnt),
    .FlushCnt  (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0; MulRdE = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MulReqD = 0; MulStartE = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    // Inputs that would otherwise forward, stall and flush.
    RegWriteM = 1; RD_M = 5; Rs1_E = 5; Rs2_E = 5;
    ResultSrcE = 1; RD_E = 7; Rs1_D = 7; PCSrcE = 1; MulStartE = 1; MulRdE = 3;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd got %b%b want 0000", ForwardAE, ForwardBE);
    end
    checks++;
    if ({StallF, StallD, FlushD, FlushE, MulBusy, MulDoneW} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {StallF, StallD, FlushD, FlushE, MulBusy, MulDoneW});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (StallCnt !== 32'd0 || FlushCnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", StallCnt, FlushCnt);
    end
`endif
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (MulBusy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy got %b want 0", MulBusy);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5;
    #1;
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_prio got %b want 10", ForwardAE);
    end
    RD_M = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL fwd_rdm_zero got %b want 01", ForwardAE);
    end
    RegWriteW = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_no_write got %b want 00", ForwardAE);
    end
    // B path independent of A: Mem hits Rs2_E, Writeback hits Rs1_E.
    RegWriteM = 1; RD_M = 6; Rs2_E = 6; RegWriteW = 1; RD_W = 5; Rs1_E = 5;
    #1;
    checks++;
    if ({ForwardAE, ForwardBE} !== 4'b0110) begin
      errors++; $display("FAIL fwd_a_b got %b%b want 0110", ForwardAE, ForwardBE);
    end
    RD_W = 0; Rs1_E = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_x0 got %b want 00", ForwardAE);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      errors++;
      $display("FAIL lw_stall got %b want 1101", {StallF, StallD, FlushD, FlushE});
    end
    @(negedge clk);
    ResultSrcE = 0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL lw_one_cycle got %b want 000", {StallF, StallD, FlushE});
    end
    ResultSrcE = 1; RD_E = 0; Rs2_D = 0; Rs1_D = 0;
    #1;
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      errors++; $display("FAIL lw_x0 got %b want 000", {StallF, StallD, FlushE});
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    ResultSrcE = 1; RD_E = 7; Rs1_D = 7; PCSrcE = 1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      errors++;
      $display("FAIL branch_vs_stall got %b want 0011", {StallF, StallD, FlushD, FlushE});
    end
    clear_inputs();
  endtask

  task automatic test_mul_latency();
    logic exp_busy, exp_done, exp_stall;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      clear_inputs();
      Rs1_D = 9;
      MulStartE = (c == 0);
      MulRdE = 9;
      #1;
      exp_busy  = (c >= 1 && c <= 4);
      exp_done  = (c == 4);
      exp_stall = (c >= 1 && c <= 3);
      checks++;
      if ({MulBusy, MulDoneW, StallF} !== {exp_busy, exp_done, exp_stall}) begin
        errors++;
        $display("FAIL mul_lat c%0d got busy/done/stall %b%b%b want %b%b%b", c, MulBusy,
                 MulDoneW, StallF, exp_busy, exp_done, exp_stall);
      end
    end
    clear_inputs();
  endtask

  task automatic test_struct_stall();
    logic exp_busy, exp_done, exp_stall;
    // PendRd=0 never causes a data stall; MulReqD causes structural stall except on done.
    // A second start at c=2 must be ignored.
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      clear_inputs();
      MulStartE = (c == 0) || (c == 2);
      MulRdE = (c == 2) ? 5'd4 : 5'd0;
      MulReqD = (c >= 1);
      #1;
      exp_busy  = (c >= 1 && c <= 4);
      exp_done  = (c == 4);
      exp_stall = (c >= 1 && c <= 3);
      checks++;
      if ({MulBusy, MulDoneW, StallF} !== {exp_busy, exp_done, exp_stall}) begin
        errors++;
        $display("FAIL struct c%0d got busy/done/stall %b%b%b want %b%b%b", c, MulBusy,
                 MulDoneW, StallF, exp_busy, exp_done, exp_stall);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic exp_busy, exp_done;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      clear_inputs();
      MulStartE = (c == 0) || (c == 4);
      MulRdE = (c == 4) ? 5'd3 : 5'd9;
      #1;
      exp_busy = (c >= 1 && c <= 8);
      exp_done = (c == 4) || (c == 8);
      checks++;
      if ({MulBusy, MulDoneW} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL b2b c%0d got busy/done %b%b want %b%b", c, MulBusy, MulDoneW,
                 exp_busy, exp_done);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    clear_inputs();
    MulStartE = 1; MulRdE = 9;
    @(negedge clk);
    clear_inputs();
    Rs1_D = 9;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({MulBusy, MulDoneW, StallF} !== 3'b000) begin
      errors++;
      $display("FAIL abort_now got busy/done/stall %b%b%b want 000", MulBusy, MulDoneW, StallF);
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (StallCnt !== 32'd0) begin
      errors++; $display("FAIL abort_stallcnt got %0d want 0", StallCnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({MulBusy, MulDoneW} !== 2'b00) begin
        errors++; $display("FAIL abort_after c%0d got busy/done %b%b want 00", c, MulBusy, MulDoneW);
      end
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    // Counters are zero after the abort reset and nothing has stalled since.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c < 3) begin
        ResultSrcE = 1; RD_E = 2; Rs1_D = 2;
      end else begin
        PCSrcE = 1;
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (StallCnt !== 32'd3 || FlushCnt !== 32'd2) begin
      errors++; $display("FAIL perf_cnt got %0d/%0d want 3/2", StallCnt, FlushCnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mul_latency();
    test_struct_stall();
    test_back_to_back();
    test_reset_abort();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
